// File: rtl/noc_mem_responder_pkg.sv
// rtl/noc_mem_responder_pkg.sv - shared FSM state type and route-width helper for the NoC memory responder
package noc_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } resp_state_e;

    // Route tag width: one LOG_R-bit port index per tree level.
    function automatic int route_w(input int radix, input int depth);
        return $clog2(radix) * depth;
    endfunction

endpackage

// File: rtl/noc_mem_responder_if.sv
// rtl/noc_mem_responder_if.sv - C2M request, memory handshake and M2C response bundle (NOC_RESP_TIMEOUT_EN adds m2c_err)
interface noc_mem_responder_if
    import noc_mem_responder_pkg::*;
#(
    parameter int BIT_WIDTH     = 512,
    parameter int ADDR_WIDTH    = 32,
    parameter int RADIX         = 2,
    parameter int NETWORK_DEPTH = 1
);
    localparam int ROUTE_W = route_w(RADIX, NETWORK_DEPTH);

    logic                  c2m_en;
    logic                  c2m_we;
    logic [ADDR_WIDTH-1:0] c2m_addr;
    logic [BIT_WIDTH-1:0]  c2m_data;
    logic [ROUTE_W-1:0]    c2m_route;
    logic                  c2m_full;
    logic                  c2m_overflow;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [BIT_WIDTH-1:0]  mem_wdata;
    logic                  mem_ack;
    logic [BIT_WIDTH-1:0]  mem_rdata;

    logic [BIT_WIDTH-1:0]  m2c_data;
    logic [ROUTE_W:0]      m2c_access_complete;
`ifdef NOC_RESP_TIMEOUT_EN
    logic                  m2c_err;
`endif

    modport slave (
        input  c2m_en, c2m_we, c2m_addr, c2m_data, c2m_route,
        output c2m_full, c2m_overflow,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output m2c_data, m2c_access_complete
`ifdef NOC_RESP_TIMEOUT_EN
        , output m2c_err
`endif
    );

    modport master (
        output c2m_en, c2m_we, c2m_addr, c2m_data, c2m_route,
        input  c2m_full, c2m_overflow,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  m2c_data, m2c_access_complete
`ifdef NOC_RESP_TIMEOUT_EN
        , input m2c_err
`endif
    );

endinterface

// File: rtl/noc_mem_responder_fifo.sv
// rtl/noc_mem_responder_fifo.sv - synchronous request FIFO with registered full/empty flags
module noc_mem_responder_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok;
    logic             pop_ok;

    // Gate push/pop by the registered flags; a push while full is dropped even if a pop frees a slot this cycle.
    always_comb begin
        push_ok  = push & ~full_q;
        pop_ok   = pop & ~empty_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Payload storage needs no reset; occupancy tracking decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign full      = full_q;
    assign empty     = empty_q;

endmodule

// File: rtl/noc_mem_responder.sv
// rtl/noc_mem_responder.sv - NoC memory-end responder: queue C2M requests, access memory, return M2C responses (option NOC_RESP_TIMEOUT_EN)
module noc_mem_responder
    import noc_mem_responder_pkg::*;
#(
`ifdef NOC_RESP_TIMEOUT_EN
    parameter int TIMEOUT       = 255,
`endif
    parameter int BIT_WIDTH     = 512,
    parameter int ADDR_WIDTH    = 32,
    parameter int RADIX         = 2,
    parameter int NETWORK_DEPTH = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst_l,
    noc_mem_responder_if.slave bus
);
    localparam int ROUTE_W = route_w(RADIX, NETWORK_DEPTH);

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [BIT_WIDTH-1:0]  data;
        logic [ROUTE_W-1:0]    route;
    } req_t;

    req_t                 push_req;
    req_t                 head_req;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;

    resp_state_e          state_q, state_d;
    logic [BIT_WIDTH-1:0] data_q, data_d;
    logic [ROUTE_W-1:0]   route_q, route_d;
    logic                 overflow_q, overflow_d;

`ifdef NOC_RESP_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 err_q, err_d;
`endif

    assign push_req = '{we: bus.c2m_we, addr: bus.c2m_addr, data: bus.c2m_data, route: bus.c2m_route};

    noc_mem_responder_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_l     (rst_l),
        .push      (bus.c2m_en),
        .push_data (push_req),
        .pop       (fifo_pop),
        .head_data (head_req),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Access sequencing: wait for a queued request, hold it on the memory port until ack, then present one response cycle.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        route_d    = route_q;
        fifo_pop   = 1'b0;
        overflow_d = overflow_q | (bus.c2m_en & fifo_full);
`ifdef NOC_RESP_TIMEOUT_EN
        tmo_d      = '0;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_ack) begin
                    fifo_pop = 1'b1;
                    data_d   = head_req.we ? '0 : bus.mem_rdata;
                    route_d  = head_req.route;
                    state_d  = RESP;
`ifdef NOC_RESP_TIMEOUT_EN
                    err_d    = 1'b0;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    fifo_pop = 1'b1;
                    data_d   = '0;
                    route_d  = head_req.route;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    tmo_d    = tmo_q + 1'b1;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and response registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= IDLE;
            data_q     <= '0;
            route_q    <= '0;
            overflow_q <= 1'b0;
`ifdef NOC_RESP_TIMEOUT_EN
            tmo_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            route_q    <= route_d;
            overflow_q <= overflow_d;
`ifdef NOC_RESP_TIMEOUT_EN
            tmo_q      <= tmo_d;
            err_q      <= err_d;
`endif
        end
    end

    assign bus.c2m_full            = fifo_full;
    assign bus.c2m_overflow        = overflow_q;
    assign bus.mem_req             = (state_q == ISSUE);
    assign bus.mem_we              = head_req.we;
    assign bus.mem_addr            = head_req.addr;
    assign bus.mem_wdata           = head_req.data;
    assign bus.m2c_data            = data_q;
    assign bus.m2c_access_complete = (state_q == RESP) ? {route_q, 1'b1} : '0;
`ifdef NOC_RESP_TIMEOUT_EN
    assign bus.m2c_err             = (state_q == RESP) & err_q;
`endif

endmodule

// File: tb/tb_noc_mem_responder.sv
// tb/tb_noc_mem_responder.sv - self-checking bench for noc_mem_responder (timeout case under NOC_RESP_TIMEOUT_EN)
module tb_noc_mem_responder;
    localparam int BW     = 512;
    localparam int AW     = 32;
    localparam int RADIX  = 4;
    localparam int NDEPTH = 2;
    localparam int RW     = 4;
    localparam int FD     = 4;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
        logic [RW-1:0] route;
        logic [RW:0]   exp_ac;
        logic [BW-1:0] exp_data;
        logic          exp_err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_l;
    always #5 clk = ~clk;

    noc_mem_responder_if #(.BIT_WIDTH(BW), .ADDR_WIDTH(AW), .RADIX(RADIX), .NETWORK_DEPTH(NDEPTH)) bus ();

    noc_mem_responder #(
`ifdef NOC_RESP_TIMEOUT_EN
        .TIMEOUT       (8),
`endif
        .BIT_WIDTH     (BW),
        .ADDR_WIDTH    (AW),
        .RADIX         (RADIX),
        .NETWORK_DEPTH (NDEPTH),
        .FIFO_DEPTH    (FD)
    ) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    int   checks   = 0;
    int   fails    = 0;
    int   resp_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;
    bit   ack_en     = 1'b1;
    int   ack_dly    = 1;
    int   wcnt       = 0;
    bit   req_seen   = 1'b0;
    bit   last_valid = 1'b0;

    function automatic logic [BW-1:0] rdata_of(input logic [AW-1:0] a);
        return {16{a ^ 32'hC0DE_0000}};
    endfunction

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: acks ack_dly cycles into a request, returns address-derived read data only on the ack cycle.
    always @(negedge clk) begin
        if (bus.mem_req && ack_en && wcnt >= ack_dly) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rdata_of(bus.mem_addr);
            wcnt          = 0;
        end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = '1;
            wcnt          = (bus.mem_req && ack_en) ? wcnt + 1 : 0;
        end
    end

    // Scoreboard: memory fields against the queue head on each new access, responses popped in order.
    always @(negedge clk) begin
        if (!bus.mem_req) req_seen = 1'b0;
        if (rst_l) begin
            if (bus.mem_req && !req_seen) begin
                req_seen = 1'b1;
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL mem_req_unexpected: addr %0h with nothing queued", bus.mem_addr);
                end else begin
                    check("mem_we", BW'(bus.mem_we), BW'(sb[0].we));
                    check("mem_addr", BW'(bus.mem_addr), BW'(sb[0].addr));
                    check("mem_wdata", bus.mem_wdata, sb[0].wdata);
                end
            end
            if (bus.m2c_access_complete[0]) begin
                resp_cnt++;
                check("resp_gap", BW'(last_valid), BW'(1'b0));
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL resp_unexpected: ac %0h with nothing queued", bus.m2c_access_complete);
                end else begin
                    mon_e = sb.pop_front();
                    check("resp_ac", BW'(bus.m2c_access_complete), BW'(mon_e.exp_ac));
                    check("resp_data", bus.m2c_data, mon_e.exp_data);
`ifdef NOC_RESP_TIMEOUT_EN
                    check("resp_err", BW'(bus.m2c_err), BW'(mon_e.exp_err));
`endif
                end
            end else if (last_valid) begin
                check("resp_one_cycle", BW'(bus.m2c_access_complete), BW'(0));
            end
            last_valid = bus.m2c_access_complete[0];
        end
    end

    task automatic drive(input exp_t e, input bit accept);
        @(posedge clk);
        #1;
        bus.c2m_en    = 1'b1;
        bus.c2m_we    = e.we;
        bus.c2m_addr  = e.addr;
        bus.c2m_data  = e.wdata;
        bus.c2m_route = e.route;
        if (accept) sb.push_back(e);
    endtask

    task automatic release_en();
        @(posedge clk);
        #1;
        bus.c2m_en = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
        check(name, BW'(sb.size()), BW'(0));
    endtask

    function automatic exp_t mk(input logic we, input logic [AW-1:0] a, input logic [BW-1:0] d,
                                input logic [RW-1:0] r, input logic [RW:0] ac, input logic err);
        exp_t e;
        e.we       = we;
        e.addr     = a;
        e.wdata    = d;
        e.route    = r;
        e.exp_ac   = ac;
        e.exp_data = (we || err) ? '0 : rdata_of(a);
        e.exp_err  = err;
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t vec[5];
        exp_t e;
        exp_t ov[5];
        int   base;
        int   n;

        vec[0] = mk(1'b0, 32'h40, {16{32'h1111_2222}}, 4'h1, 5'h03, 1'b0);
        vec[1] = mk(1'b1, 32'h80, {64{8'hA5}}, 4'h0, 5'h01, 1'b0);
        vec[2] = mk(1'b0, 32'h100, {16{32'h3333_4444}}, 4'hE, 5'h1D, 1'b0);
        vec[3] = mk(1'b0, 32'h104, {16{32'h5555_6666}}, 4'h3, 5'h07, 1'b0);
        vec[4] = mk(1'b1, 32'hFFFF_FFFC, {16{32'h0F1E_2D3C}}, 4'hF, 5'h1F, 1'b0);

        rst_l         = 1'b0;
        bus.c2m_en    = 1'b0;
        bus.c2m_we    = 1'b0;
        bus.c2m_addr  = '0;
        bus.c2m_data  = '0;
        bus.c2m_route = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_full", BW'(bus.c2m_full), BW'(0));
        check("rst_overflow", BW'(bus.c2m_overflow), BW'(0));
        check("rst_mem_req", BW'(bus.mem_req), BW'(0));
        check("rst_ac", BW'(bus.m2c_access_complete), BW'(0));
        check("rst_data", bus.m2c_data, BW'(0));
`ifdef NOC_RESP_TIMEOUT_EN
        check("rst_err", BW'(bus.m2c_err), BW'(0));
`endif
        @(negedge clk);
        rst_l = 1'b1;

        // Latency from an empty queue with a same-cycle ack.
        ack_dly = 0;
        e = mk(1'b0, 32'h300, {16{32'hABCD_0123}}, 4'h9, 5'h13, 1'b0);
        drive(e, 1'b1);
        release_en();
        check("lat_req_c1", BW'(bus.mem_req), BW'(0));
        @(posedge clk);
        #1;
        check("lat_req_c2", BW'(bus.mem_req), BW'(1));
        @(posedge clk);
        #1;
        check("lat_ac_c3", BW'(bus.m2c_access_complete), BW'(5'h13));
        check("lat_data_c3", bus.m2c_data, rdata_of(32'h300));
        @(posedge clk);
        #1;
        check("lat_ac_c4", BW'(bus.m2c_access_complete), BW'(0));
        check("lat_data_hold", bus.m2c_data, rdata_of(32'h300));
        drain("drain_lat");

        // Table of single accesses with varying memory latency.
        for (int i = 0; i < 5; i++) begin
            ack_dly = i % 3;
            drive(vec[i], 1'b1);
            release_en();
            drain("drain_vec");
        end

        // Two reads back-to-back must come back in order with their own route tags.
        ack_dly = 1;
        drive(vec[2], 1'b1);
        drive(vec[3], 1'b1);
        release_en();
        drain("drain_order");

        // Five strobes with memory stalled: four accepted, fifth dropped and flagged.
        ack_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ov[k] = mk(k[0], 32'h1000 + 32'(k * 4), {16{32'(k) ^ 32'h7777_0000}}, 4'(k + 5), {4'(k + 5), 1'b1}, 1'b0);
            drive(ov[k], k < 4);
            if (k == 4) begin
                check("ovf_full_after_4", BW'(bus.c2m_full), BW'(1));
                check("ovf_not_yet", BW'(bus.c2m_overflow), BW'(0));
            end
        end
        release_en();
        check("ovf_set", BW'(bus.c2m_overflow), BW'(1));
        base   = resp_cnt;
        ack_en = 1'b1;
        drain("drain_ovf");
        repeat (10) @(posedge clk);
        #1;
        check("ovf_resp_count", BW'(resp_cnt - base), BW'(4));
        check("ovf_full_clear", BW'(bus.c2m_full), BW'(0));
        check("ovf_sticky", BW'(bus.c2m_overflow), BW'(1));

`ifndef NOC_RESP_TIMEOUT_EN
        // Without the watchdog a stalled access waits indefinitely.
        ack_en = 1'b0;
        base   = resp_cnt;
        drive(vec[0], 1'b1);
        release_en();
        repeat (20) @(negedge clk);
        check("stall_req_held", BW'(bus.mem_req), BW'(1));
        check("stall_no_resp", BW'(resp_cnt - base), BW'(0));
        ack_en = 1'b1;
        drain("drain_stall");
`endif

        // Asynchronous reset in the middle of a stalled access with a full queue.
        ack_en = 1'b0;
        for (int k = 0; k < 4; k++) drive(ov[k], 1'b1);
        release_en();
        check("rstm_req_before", BW'(bus.mem_req), BW'(1));
        check("rstm_full_before", BW'(bus.c2m_full), BW'(1));
        #2;
        rst_l = 1'b0;
        #1;
        check("rstm_req_drop", BW'(bus.mem_req), BW'(0));
        check("rstm_ac_drop", BW'(bus.m2c_access_complete), BW'(0));
        check("rstm_full_drop", BW'(bus.c2m_full), BW'(0));
        check("rstm_ovf_clear", BW'(bus.c2m_overflow), BW'(0));
        check("rstm_data_clear", bus.m2c_data, BW'(0));
        sb.delete();
        repeat (2) @(negedge clk);
        rst_l  = 1'b1;
        ack_en = 1'b1;
        base   = resp_cnt;
        drive(vec[0], 1'b1);
        release_en();
        drain("drain_post_rst");
        check("post_rst_resp_count", BW'(resp_cnt - base), BW'(1));

`ifdef NOC_RESP_TIMEOUT_EN
        // Watchdog: first read times out after 8 ISSUE cycles, second is then issued and completes.
        ack_en  = 1'b0;
        ack_dly = 1;
        drive(mk(1'b0, 32'h200, {16{32'h2468_ACE0}}, 4'h5, 5'h0B, 1'b1), 1'b1);
        drive(mk(1'b0, 32'h204, {16{32'h1357_9BDF}}, 4'hA, 5'h15, 1'b0), 1'b1);
        release_en();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.m2c_access_complete[0]) break;
            if (bus.mem_req) n++;
        end
        check("tmo_valid", BW'(bus.m2c_access_complete[0]), BW'(1));
        check("tmo_issue_cycles", BW'(n), BW'(8));
        ack_en = 1'b1;
        drain("drain_tmo");
`else
        n = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
